// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and types for the round-robin grant arbiter
package arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int IDX_W = 2;
  typedef enum logic {IDLE, GRANT} state_t;
  typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority search, first set req bit from ptr upward with wrap
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  idx_t               ptr,
  output idx_t               win_idx,
  output logic               any_req
);
  always_comb begin
    win_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_t c;
      c = ptr + IDX_W'(k);
      if (req[c]) win_idx = c;
    end
  end
  assign any_req = |req;
endmodule

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: 4-way round-robin arbiter driving a 2-to-4 decoder select
// ARB_TIMEOUT_EN enables the HOLD_MAX hold timeout and the timeout_pulse port
module rr_grant_arbiter
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W = 8
)
`endif
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
`ifdef ARB_TIMEOUT_EN
  output logic               timeout_pulse,
`endif
  output idx_t               gnt_idx,
  output logic               gnt_valid,
  output logic               busy
);
  state_t state, state_nx;
  idx_t ptr, win_idx;
  logic any_req, timeout, release_now;
  rr_pick u_pick (.req(req), .ptr(ptr), .win_idx(win_idx), .any_req(any_req));
`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  assign timeout = hold_cnt == CNT_W'(HOLD_MAX - 1);
  // timeout_pulse flags releases caused only by the timeout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      hold_cnt <= state == GRANT ? hold_cnt + 1'b1 : '0;
      timeout_pulse <= state == GRANT && timeout && !done && req[gnt_idx];
    end
  end
`else
  assign timeout = 1'b0;
`endif
  assign release_now = done || !req[gnt_idx] || timeout;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = en && any_req ? GRANT : IDLE;
    else state_nx = release_now ? IDLE : GRANT;
  end
  always_comb begin
    gnt_valid = state == GRANT;
    busy = state == GRANT;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_idx <= '0;
      ptr <= '0;
    end else if (state == IDLE && en && any_req) begin
      gnt_idx <= win_idx;
    end else if (state == GRANT && release_now) begin
      ptr <= gnt_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: directed checks of the round-robin arbiter (ARB_TIMEOUT_EN optional)
module tb_rr_grant_arbiter;
  logic clk = 1'b0;
  logic rst_n, en, done;
  logic [3:0] req;
  logic [1:0] gnt_idx;
  logic gnt_valid, busy;
  int n_run = 0;
  int n_fail = 0;
`ifdef ARB_TIMEOUT_EN
  logic timeout_pulse;
  rr_grant_arbiter #(.HOLD_MAX(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
    .timeout_pulse(timeout_pulse),
    .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .busy(busy));
`else
  rr_grant_arbiter dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
    .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .busy(busy));
`endif
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_grant(input string tag, input int v, input int idx);
    check({tag, "_valid"}, int'(gnt_valid), v);
    check({tag, "_busy"}, int'(busy), v);
    if (v != 0) check({tag, "_idx"}, int'(gnt_idx), idx);
  endtask
  initial begin
    int seq[4] = '{1, 2, 3, 0};
    rst_n = 1'b0; en = 1'b1; done = 1'b0; req = 4'b1111;
    step(); step();
    expect_grant("reset", 0, 0);
    check("reset_idx", int'(gnt_idx), 0);
    rst_n = 1'b1;
    step();
    expect_grant("first", 1, 0);
    foreach (seq[i]) begin
      done = 1'b1;
      step();
      expect_grant("rr_gap", 0, 0);
      done = 1'b0;
      step();
      expect_grant("rr_seq", 1, seq[i]);
    end
    req = 4'b0010; done = 1'b1;
    step();
    expect_grant("rel0", 0, 0);
    done = 1'b0;
    step();
    expect_grant("gnt1", 1, 1);
    req = 4'b0011; done = 1'b1;
    step();
    expect_grant("rel1", 0, 0);
    done = 1'b0;
    step();
    expect_grant("wrap", 1, 0);
    req = 4'b0110;
    step();
    expect_grant("reqdrop", 0, 0);
    step();
    expect_grant("after_drop", 1, 1);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      expect_grant("hold", 1, 1);
      check("pulse_low", int'(timeout_pulse), 0);
    end
    step();
    expect_grant("timeout_rel", 0, 0);
    check("timeout_pulse", int'(timeout_pulse), 1);
    step();
    expect_grant("post_timeout", 1, 2);
    check("pulse_clear", int'(timeout_pulse), 0);
    step(); step(); step();
    done = 1'b1;
    step();
    expect_grant("done_timeout", 0, 0);
    check("done_timeout_pulse", int'(timeout_pulse), 0);
    done = 1'b0;
`else
    begin
      int held = 1;
      for (int i = 0; i < 20; i++) begin
        step();
        if (!(gnt_valid && gnt_idx == 2'd1)) held = 0;
      end
      check("long_hold", held, 1);
    end
    done = 1'b1;
    step();
    expect_grant("long_rel", 0, 0);
    done = 1'b0;
    step();
    expect_grant("next_after_hold", 1, 2);
    done = 1'b1;
    step();
    expect_grant("rel2", 0, 0);
    done = 1'b0;
`endif
    req = 4'b1000;
    step();
    expect_grant("gnt3", 1, 3);
    en = 1'b0; req = 4'b1001;
    step();
    expect_grant("en_off_hold", 1, 3);
    done = 1'b1;
    step();
    expect_grant("en_off_rel", 0, 0);
    done = 1'b0; req = 4'b0001;
    step();
    expect_grant("en_off_idle1", 0, 0);
    step();
    expect_grant("en_off_idle2", 0, 0);
    en = 1'b1;
    step();
    expect_grant("en_on", 1, 0);
    rst_n = 1'b0;
    step();
    expect_grant("mid_reset", 0, 0);
    check("mid_reset_idx", int'(gnt_idx), 0);
    rst_n = 1'b1; req = 4'b0000;
    step();
    expect_grant("no_req", 0, 0);
    req = 4'b0100;
    step();
    expect_grant("after_reset", 1, 2);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
